// File: rtl/rtc_alarm_irq_ctrl_pkg.sv
// Shared types for the RTC alarm interrupt controller: calendar time record,
// mask bit positions and the per-channel state encoding.
package rtc_pkg;

  parameter int YEAR_W = 12;

  // Mask bit positions; bit i set means field i is ignored by the comparator.
  localparam int FLD_SEC   = 0;
  localparam int FLD_MIN   = 1;
  localparam int FLD_HOUR  = 2;
  localparam int FLD_MODE  = 3;
  localparam int FLD_DOW   = 4;
  localparam int FLD_DOM   = 5;
  localparam int FLD_MONTH = 6;
  localparam int FLD_YEAR  = 7;
  localparam int N_FIELDS  = 8;

  typedef struct packed {
    logic [YEAR_W-1:0] year;
    logic [3:0]        month;
    logic [4:0]        dom;
    logic [2:0]        dow;
    logic              mode;
    logic [4:0]        hour;
    logic [5:0]        min;
    logic [5:0]        sec;
  } rtc_time_t;

  typedef enum logic [1:0] {
    CH_DISABLED = 2'b00,
    CH_ARMED    = 2'b01,
    CH_PENDING  = 2'b10
  } ch_state_e;

  // A field matches when it is equal or masked out; all fields must match.
  function automatic logic fields_match(input logic [N_FIELDS-1:0] eq,
                                        input logic [N_FIELDS-1:0] mask);
    return &(eq | mask);
  endfunction

endpackage

// File: rtl/rtc_alarm_irq_ctrl_if.sv
// Channel configuration and interrupt acknowledge bus of the alarm controller.
interface rtc_alarm_irq_ctrl_if
  import rtc_pkg::*;
#(
  parameter int N_CH = 4
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic            cfg_we_i;
  logic [CH_W-1:0] cfg_ch_i;
  rtc_time_t       cfg_time_i;
  logic [7:0]      cfg_mask_i;
  logic            cfg_en_i;
  logic            cfg_periodic_i;
  logic            irq_ack_i;
  logic [CH_W-1:0] irq_ack_ch_i;

  modport master (
    output cfg_we_i, cfg_ch_i, cfg_time_i, cfg_mask_i, cfg_en_i,
           cfg_periodic_i, irq_ack_i, irq_ack_ch_i
  );

  modport slave (
    input cfg_we_i, cfg_ch_i, cfg_time_i, cfg_mask_i, cfg_en_i,
          cfg_periodic_i, irq_ack_i, irq_ack_ch_i
  );

endinterface

// File: rtl/rtc_alarm_irq_ctrl_ch.sv
// One alarm channel: stored alarm time and mask, tick-qualified comparator and
// the DISABLED / ARMED / PENDING state machine with sticky missed flag.
module rtc_alarm_ch
  import rtc_pkg::*;
#(
  parameter int YEAR_W = rtc_pkg::YEAR_W
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  rtc_time_t  cur_time_i,
  input  logic       tick_i,
  input  logic       cfg_we_i,
  input  rtc_time_t  cfg_time_i,
  input  logic [7:0] cfg_mask_i,
  input  logic       cfg_en_i,
  input  logic       cfg_periodic_i,
  input  logic       ack_i,
  output logic       pending_o,
  output logic       missed_o
);

  ch_state_e  state_q, state_d;
  rtc_time_t  alarm_q, alarm_d;
  logic [7:0] mask_q, mask_d;
  logic       periodic_q, periodic_d;
  logic       pending_q, pending_d;
  logic       missed_q, missed_d;
  logic [7:0] eq_s;
  logic       match_s;

  // Per-field equality between the live time and the stored alarm.
  always_comb begin
    eq_s            = 8'h00;
    eq_s[FLD_SEC]   = (cur_time_i.sec   == alarm_q.sec);
    eq_s[FLD_MIN]   = (cur_time_i.min   == alarm_q.min);
    eq_s[FLD_HOUR]  = (cur_time_i.hour  == alarm_q.hour);
    eq_s[FLD_MODE]  = (cur_time_i.mode  == alarm_q.mode);
    eq_s[FLD_DOW]   = (cur_time_i.dow   == alarm_q.dow);
    eq_s[FLD_DOM]   = (cur_time_i.dom   == alarm_q.dom);
    eq_s[FLD_MONTH] = (cur_time_i.month == alarm_q.month);
    eq_s[FLD_YEAR]  = (cur_time_i.year[YEAR_W-1:0] == alarm_q.year[YEAR_W-1:0]);
  end

  assign match_s = tick_i & fields_match(eq_s, mask_q);

  // Next state; a configuration write overrides any match in the same cycle.
  always_comb begin
    state_d    = state_q;
    alarm_d    = alarm_q;
    mask_d     = mask_q;
    periodic_d = periodic_q;
    missed_d   = missed_q;
    if (cfg_we_i) begin
      alarm_d    = cfg_time_i;
      mask_d     = cfg_mask_i;
      periodic_d = cfg_periodic_i;
      state_d    = cfg_en_i ? CH_ARMED : CH_DISABLED;
      missed_d   = 1'b0;
    end else begin
      case (state_q)
        CH_DISABLED: state_d = CH_DISABLED;
        CH_ARMED:    state_d = match_s ? CH_PENDING : CH_ARMED;
        CH_PENDING: begin
          if (ack_i) begin
            // A periodic alarm recurring on the ack cycle re-raises at once.
            missed_d = 1'b0;
            state_d  = periodic_q ? (match_s ? CH_PENDING : CH_ARMED) : CH_DISABLED;
          end else begin
            missed_d = missed_q | (match_s & periodic_q);
          end
        end
        default: begin
          state_d  = CH_DISABLED;
          missed_d = 1'b0;
        end
      endcase
    end
  end

  assign pending_d = (state_d == CH_PENDING);

  // Channel state and configuration registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= CH_DISABLED;
      alarm_q    <= '0;
      mask_q     <= 8'h00;
      periodic_q <= 1'b0;
      pending_q  <= 1'b0;
      missed_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      alarm_q    <= alarm_d;
      mask_q     <= mask_d;
      periodic_q <= periodic_d;
      pending_q  <= pending_d;
      missed_q   <= missed_d;
    end
  end

  assign pending_o = pending_q;
  assign missed_o  = missed_q;

endmodule

// File: rtl/rtc_alarm_irq_ctrl.sv
// RTC alarm interrupt controller: N_CH alarm channels, lowest-index interrupt
// priority encoder and a time snapshot register.
module rtc_alarm_irq_ctrl
  import rtc_pkg::*;
#(
  parameter  int N_CH   = 4,
  parameter  int YEAR_W = rtc_pkg::YEAR_W,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  rtc_time_t           cur_time_i,
  input  logic                tick_i,
  rtc_alarm_irq_ctrl_if.slave cfg_if,
  input  logic                snap_i,
  output logic                irq_o,
  output logic [CH_W-1:0]     irq_id_o,
  output logic [N_CH-1:0]     pending_o,
  output logic [N_CH-1:0]     missed_o,
  output rtc_time_t           snap_time_o,
  output logic                snap_valid_o
);

  logic [N_CH-1:0] ch_we_s;
  logic [N_CH-1:0] ch_ack_s;
  logic [N_CH-1:0] pending_s;
  logic [N_CH-1:0] missed_s;
  logic [CH_W-1:0] irq_id_s;
  rtc_time_t       snap_time_q, snap_time_d;
  logic            snap_valid_q;

  // Out-of-range channel indices select no channel and are dropped here.
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign ch_we_s[g]  = cfg_if.cfg_we_i  & (int'(cfg_if.cfg_ch_i) == g);
    assign ch_ack_s[g] = cfg_if.irq_ack_i & (int'(cfg_if.irq_ack_ch_i) == g);

    rtc_alarm_ch #(
      .YEAR_W (YEAR_W)
    ) u_ch (
      .clk_i          (clk_i),
      .rstn_i         (rstn_i),
      .cur_time_i     (cur_time_i),
      .tick_i         (tick_i),
      .cfg_we_i       (ch_we_s[g]),
      .cfg_time_i     (cfg_if.cfg_time_i),
      .cfg_mask_i     (cfg_if.cfg_mask_i),
      .cfg_en_i       (cfg_if.cfg_en_i),
      .cfg_periodic_i (cfg_if.cfg_periodic_i),
      .ack_i          (ch_ack_s[g]),
      .pending_o      (pending_s[g]),
      .missed_o       (missed_s[g])
    );
  end

  // Lowest pending index wins; scanning downward leaves the smallest one.
  always_comb begin
    irq_id_s = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      irq_id_s = pending_s[i] ? CH_W'(i) : irq_id_s;
    end
  end

  assign snap_time_d = snap_i ? cur_time_i : snap_time_q;

  // Snapshot capture and its one-cycle valid strobe.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      snap_time_q  <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      snap_time_q  <= snap_time_d;
      snap_valid_q <= snap_i;
    end
  end

  assign irq_o        = |pending_s;
  assign irq_id_o     = irq_id_s;
  assign pending_o    = pending_s;
  assign missed_o     = missed_s;
  assign snap_time_o  = snap_time_q;
  assign snap_valid_o = snap_valid_q;

endmodule

// File: tb/tb_rtc_alarm_irq_ctrl.sv
// Directed, table-driven bench for rtc_alarm_irq_ctrl with hand-written
// sequences for snapshots and asynchronous reset.
module tb_rtc_alarm_irq_ctrl;
  import rtc_pkg::*;

  localparam int N_CH = 4;
  localparam int CH_W = 2;

  logic            clk = 1'b0;
  logic            rstn;
  rtc_time_t       cur_time;
  logic            tick;
  logic            snap;
  logic            irq;
  logic [CH_W-1:0] irq_id;
  logic [N_CH-1:0] pending;
  logic [N_CH-1:0] missed;
  rtc_time_t       snap_time;
  logic            snap_valid;

  always #5 clk = ~clk;

  rtc_alarm_irq_ctrl_if #(.N_CH(N_CH)) cfg_if ();

  rtc_alarm_irq_ctrl #(.N_CH(N_CH), .YEAR_W(12)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .cur_time_i   (cur_time),
    .tick_i       (tick),
    .cfg_if       (cfg_if),
    .snap_i       (snap),
    .irq_o        (irq),
    .irq_id_o     (irq_id),
    .pending_o    (pending),
    .missed_o     (missed),
    .snap_time_o  (snap_time),
    .snap_valid_o (snap_valid)
  );

  typedef struct {
    string           name;
    logic            tick;
    rtc_time_t       t;
    logic            we;
    logic [CH_W-1:0] ch;
    logic [7:0]      mask;
    logic            en;
    logic            per;
    logic            ack;
    logic [CH_W-1:0] ack_ch;
    logic [N_CH-1:0] e_pend;
    logic [N_CH-1:0] e_miss;
    logic [CH_W-1:0] e_id;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  function automatic rtc_time_t mk_time(input int year, input int month, input int dom,
                                        input int dow, input int mode, input int hour,
                                        input int min, input int sec);
    rtc_time_t r;
    r.year  = 12'(year);
    r.month = 4'(month);
    r.dom   = 5'(dom);
    r.dow   = 3'(dow);
    r.mode  = 1'(mode);
    r.hour  = 5'(hour);
    r.min   = 6'(min);
    r.sec   = 6'(sec);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input string name, input logic tk, input rtc_time_t t,
                      input logic we, input int ch, input logic [7:0] mask,
                      input logic en, input logic per, input logic ack, input int ack_ch,
                      input logic [3:0] e_pend, input logic [3:0] e_miss, input int e_id);
    vec_t v;
    v.name = name; v.tick = tk; v.t = t; v.we = we; v.ch = CH_W'(ch);
    v.mask = mask; v.en = en; v.per = per; v.ack = ack; v.ack_ch = CH_W'(ack_ch);
    v.e_pend = e_pend; v.e_miss = e_miss; v.e_id = CH_W'(e_id);
    vecs.push_back(v);
  endtask

  task automatic drive(input logic tk, input rtc_time_t t, input logic we, input int ch,
                       input logic [7:0] mask, input logic en, input logic per,
                       input logic ack, input int ack_ch);
    tick                  = tk;
    cur_time              = t;
    snap                  = 1'b0;
    cfg_if.cfg_we_i       = we;
    cfg_if.cfg_ch_i       = CH_W'(ch);
    cfg_if.cfg_time_i     = t;
    cfg_if.cfg_mask_i     = mask;
    cfg_if.cfg_en_i       = en;
    cfg_if.cfg_periodic_i = per;
    cfg_if.irq_ack_i      = ack;
    cfg_if.irq_ack_ch_i   = CH_W'(ack_ch);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pending"}, 64'(pending), 64'h0);
    check({tag, "_missed"}, 64'(missed), 64'h0);
    check({tag, "_irq"}, 64'(irq), 64'h0);
    check({tag, "_irq_id"}, 64'(irq_id), 64'h0);
    check({tag, "_snap_time"}, 64'(snap_time), 64'h0);
    check({tag, "_snap_valid"}, 64'(snap_valid), 64'h0);
  endtask

  initial begin
    rtc_time_t t0, t_1230, t_1229, t_match, t_2023;
    t0      = mk_time(0, 0, 0, 0, 0, 0, 0, 0);
    t_1230  = mk_time(0, 0, 0, 0, 0, 12, 30, 0);
    t_1229  = mk_time(0, 0, 0, 0, 0, 12, 29, 59);
    t_match = mk_time(2024, 5, 17, 3, 1, 12, 30, 0);
    t_2023  = mk_time(2023, 1, 1, 0, 0, 0, 0, 0);

    push("no_cfg_tick",      1'b1, t_1230,  1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 4'b0000, 4'b0000, 0);
    push("cfg_ch1_oneshot",  1'b0, t_1230,  1'b1, 1, 8'hF8, 1'b1, 1'b0, 1'b0, 0, 4'b0000, 4'b0000, 0);
    push("tick_nomatch",     1'b1, t_1229,  1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 4'b0000, 4'b0000, 0);
    push("tick_match_ch1",   1'b1, t_match, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 4'b0010, 4'b0000, 1);
    push("hold_ch1",         1'b0, t_match, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 4'b0010, 4'b0000, 1);
    push("ack_ch1",          1'b0, t_match, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b1, 1, 4'b0000, 4'b0000, 0);
    push("oneshot_retick",   1'b1, t_match, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 4'b0000, 4'b0000, 0);
    push("cfg_ch0_per",      1'b0, t_1230,  1'b1, 0, 8'hFF, 1'b1, 1'b1, 1'b0, 0, 4'b0000, 4'b0000, 0);
    push("cfg_ch2_per",      1'b0, t_1230,  1'b1, 2, 8'hFF, 1'b1, 1'b1, 1'b0, 0, 4'b0000, 4'b0000, 0);
    push("tick_ch0_ch2",     1'b1, t_1229,  1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 4'b0101, 4'b0000, 0);
    push("retick_missed",    1'b1, t_match, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 4'b0101, 4'b0101, 0);
    push("ack_ch0",          1'b0, t_match, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b1, 0, 4'b0100, 4'b0100, 2);
    push("cfg_ch3_per",      1'b0, t_1230,  1'b1, 3, 8'hFF, 1'b1, 1'b1, 1'b0, 0, 4'b0100, 4'b0100, 2);
    push("tick_three",       1'b1, t_1230,  1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 4'b1101, 4'b0100, 0);
    push("ack3_with_tick",   1'b1, t_1230,  1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b1, 3, 4'b1101, 4'b0101, 0);
    push("cfg_beats_tick",   1'b1, t_1230,  1'b1, 2, 8'hFF, 1'b0, 1'b1, 1'b0, 0, 4'b1001, 4'b1001, 0);
    push("cfg_ch1_allmask",  1'b0, t_1230,  1'b1, 1, 8'hFF, 1'b1, 1'b0, 1'b0, 0, 4'b1001, 4'b1001, 0);
    push("tick_ch1",         1'b1, t_1229,  1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 4'b1011, 4'b1001, 0);
    push("oneshot_ack_tick", 1'b1, t_1229,  1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b1, 1, 4'b1001, 4'b1001, 0);
    push("ack_ch0_again",    1'b0, t_1229,  1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b1, 0, 4'b1000, 4'b1000, 3);
    push("ack_disabled_ch1", 1'b0, t_1229,  1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b1, 1, 4'b1000, 4'b1000, 3);
    push("ack_ch3",          1'b0, t_1229,  1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b1, 3, 4'b0000, 4'b0000, 0);

    rstn = 1'b0;
    drive(1'b0, t0, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 0);
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rstn = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      drive(vecs[i].tick, vecs[i].t, vecs[i].we, int'(vecs[i].ch), vecs[i].mask,
            vecs[i].en, vecs[i].per, vecs[i].ack, int'(vecs[i].ack_ch));
      @(negedge clk);
      check({vecs[i].name, "_pending"}, 64'(pending), 64'(vecs[i].e_pend));
      check({vecs[i].name, "_missed"}, 64'(missed), 64'(vecs[i].e_miss));
      check({vecs[i].name, "_irq"}, 64'(irq), 64'(vecs[i].e_pend != 4'b0000));
      check({vecs[i].name, "_irq_id"}, 64'(irq_id), 64'(vecs[i].e_id));
    end

    // Snapshots: single capture, back-to-back capture, then strobe drops.
    drive(1'b0, t_2023, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 0);
    snap = 1'b1;
    @(negedge clk);
    check("snap1_time", 64'(snap_time), 64'(t_2023));
    check("snap1_valid", 64'(snap_valid), 64'h1);
    cur_time = t_match;
    @(negedge clk);
    check("snap2_time", 64'(snap_time), 64'(t_match));
    check("snap2_valid", 64'(snap_valid), 64'h1);
    drive(1'b0, t_1230, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    check("snap_hold_time", 64'(snap_time), 64'(t_match));
    check("snap_hold_valid", 64'(snap_valid), 64'h0);

    // Raise all four channels, then reset asynchronously mid-cycle.
    drive(1'b0, t_1230, 1'b1, 1, 8'hFF, 1'b1, 1'b1, 1'b0, 0);
    @(negedge clk);
    drive(1'b0, t_1230, 1'b1, 2, 8'hFF, 1'b1, 1'b1, 1'b0, 0);
    @(negedge clk);
    drive(1'b1, t_1230, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    check("all_pending", 64'(pending), 64'hF);
    drive(1'b0, t_1230, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 0);
    #2 rstn = 1'b0;
    #1 check_all_zero("async_reset");

    // Activity while in reset must leave no trace.
    drive(1'b1, t_1230, 1'b1, 0, 8'hFF, 1'b1, 1'b1, 1'b1, 0);
    snap = 1'b1;
    repeat (2) @(negedge clk);
    check("in_reset_pending", 64'(pending), 64'h0);
    check("in_reset_snap_valid", 64'(snap_valid), 64'h0);
    drive(1'b0, t_1230, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 0);
    rstn = 1'b1;
    @(negedge clk);
    drive(1'b1, t_1230, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    check("post_reset_tick_pending", 64'(pending), 64'h0);
    check("post_reset_tick_irq", 64'(irq), 64'h0);
    drive(1'b0, t_1230, 1'b1, 0, 8'hFF, 1'b1, 1'b1, 1'b0, 0);
    @(negedge clk);
    drive(1'b1, t_1229, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    check("rearm_pending", 64'(pending), 64'h1);
    check("rearm_irq", 64'(irq), 64'h1);
    check("rearm_irq_id", 64'(irq_id), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
